// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared definitions for the stopwatch control slice.
//   mode_t            2-bit mode encoding (RUN / PAUSE / ADJ; 3 unused)
//   *_DEF constants   default clock, debounce and scan-divider settings
package stopwatch_pkg;

  typedef enum logic [1:0] {
    MODE_RUN   = 2'd0,
    MODE_PAUSE = 2'd1,
    MODE_ADJ   = 2'd2
  } mode_t;

  localparam int CLK_HZ_DEF     = 100_000_000;
  localparam int DEB_CYCLES_DEF = 1_000_000;
  localparam int SCAN_DIV_DEF   = 100_000;

endpackage

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// btn_debounce: 2-flop synchronizer, debounce counter and rise-edge pulse
// for one raw button.
//   clk, rst  clock, synchronous active-high reset
//   raw       asynchronous raw button level
//   press     registered one-cycle pulse on each accepted rising edge
// The debounced level follows the synchronized level only after the two
// have disagreed for DEB_CYCLES consecutive cycles; any agreement in
// between restarts the count, so short glitches never reach the level.
module btn_debounce #(
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          s1, s2;
  logic          level, level_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      if (s2 != level) begin
        if (cnt == CW'(DEB_CYCLES - 1)) begin
          level <= s2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
      level_d <= level;
      press   <= level & ~level_d;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: input conditioning, time bases and RUN/PAUSE/ADJ mode
// machine for the stopwatch counter.
//   clk, rst            clock, synchronous active-high reset
//   btn_pse, btn_rst    raw pause / reset buttons (debounced here)
//   sw_sel, sw_adj      raw select (1 = seconds) / adjust switches
//   inc_sec, inc_min    one-cycle increment strobes to the counter
//   cnt_clr             one-cycle clear strobe to the counter
//   blink               blank the selected field while adjusting
//   scan_tick           one-cycle display digit-advance strobe
//   mode                current mode (mode_t)
// Optional feature macro: STOPWATCH_BLINK_EN (1 Hz blink in ADJ);
// without it blink is tied low.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ     = CLK_HZ_DEF,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int SCAN_DIV   = SCAN_DIV_DEF
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  btn_pse,
  input  logic  btn_rst,
  input  logic  sw_sel,
  input  logic  sw_adj,
  output logic  inc_sec,
  output logic  inc_min,
  output logic  cnt_clr,
  output logic  blink,
  output logic  scan_tick,
  output mode_t mode
);

  localparam int PW = $clog2(CLK_HZ);
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  // bit 0 = pause, bit 1 = reset
  logic [1:0] btn_raw, btn_press;
  logic       pse_press, rst_press;

  logic          sel_s1, sel_s, adj_s1, adj_s;
  logic [PW-1:0] p;
  logic [SW-1:0] sc;
  logic          paused, paused_nx;
  logic          tick1, tick2;

  assign btn_raw = {btn_rst, btn_pse};

  for (genvar g = 0; g < 2; g++) begin : g_deb
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn_raw[g]),
      .press (btn_press[g])
    );
  end

  assign pse_press = btn_press[0];
  assign rst_press = btn_press[1];

  assign tick1 = (p == PW'(CLK_HZ - 1));
  assign tick2 = tick1 || (p == PW'(CLK_HZ / 2 - 1));

  // reset press overrides a simultaneous pause press
  assign paused_nx = rst_press ? 1'b0 : (paused ^ pse_press);

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_s1    <= 1'b0;
      sel_s     <= 1'b0;
      adj_s1    <= 1'b0;
      adj_s     <= 1'b0;
      p         <= '0;
      sc        <= '0;
      paused    <= 1'b0;
      inc_sec   <= 1'b0;
      inc_min   <= 1'b0;
      cnt_clr   <= 1'b0;
      scan_tick <= 1'b0;
      mode      <= MODE_RUN;
    end else begin
      sel_s1 <= sw_sel;
      sel_s  <= sel_s1;
      adj_s1 <= sw_adj;
      adj_s  <= adj_s1;

      // prescaler realigns to the clear so the next second is a full one
      p <= (rst_press || tick1) ? '0 : p + PW'(1);

      // scan base is free-running, untouched by reset presses
      sc        <= (sc == SW'(SCAN_DIV - 1)) ? '0 : sc + SW'(1);
      scan_tick <= (sc == SW'(SCAN_DIV - 1));

      paused  <= paused_nx;
      cnt_clr <= rst_press;
      inc_sec <= !rst_press && (adj_s ? (tick2 && sel_s) : (!paused && tick1));
      inc_min <= !rst_press && adj_s && tick2 && !sel_s;

      if (adj_s)          mode <= MODE_ADJ;
      else if (paused_nx) mode <= MODE_PAUSE;
      else                mode <= MODE_RUN;
    end
  end

`ifdef STOPWATCH_BLINK_EN
  always_ff @(posedge clk) begin
    if (rst || !adj_s) blink <= 1'b0;
    else if (tick2)    blink <= ~blink;
  end
`else
  assign blink = 1'b0;
`endif

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control and timing block for the stopwatch counter. It conditions the raw pause and reset buttons and the select and adjust switches, and generates the prescaled time bases. It also runs the RUN/PAUSE/ADJ mode machine and drives one-cycle increment, clear and display-scan strobes to the minutes/seconds counter and the display driver. The counter itself holds no timing or mode logic.

## Interface
- CLK_HZ, 100_000_000, input clock frequency; must be even and ≥4
- DEB_CYCLES, 1_000_000, cycles a synchronized button level must be stable to be accepted
- SCAN_DIV, 100_000, clock cycles per display scan strobe
- clk  in  1  system clock, single clock domain
- rst  in  1  synchronous, active-high system reset
- btn_pse  in  1  raw pause button, asynchronous, active-high
- btn_rst  in  1  raw reset button, asynchronous, active-high
- sw_sel  in  1  raw select switch; 0 = minutes, 1 = seconds
- sw_adj  in  1  raw adjust switch; 1 = adjust mode
- inc_sec  out  1  one-cycle strobe: seconds +1, with carry into minutes
- inc_min  out  1  one-cycle strobe: minutes +1, no carry
- cnt_clr  out  1  one-cycle strobe: counter to 00:00
- blink  out  1  display blank for the selected field in ADJ
- scan_tick  out  1  one-cycle display digit-advance strobe
- mode  out  2  0 RUN, 1 PAUSE, 2 ADJ

## Operation
- All four raw inputs pass through 2-flop synchronizers. The buttons are then debounced: the debounced level changes only after the synchronized level has differed from it for DEB_CYCLES consecutive cycles. A rising edge on the debounced level gives a one-cycle press pulse. The switches are used as synchronized levels.
- Prescaler p counts 0..CLK_HZ-1 and wraps. tick1 fires when p==CLK_HZ-1. tick2 fires when p==CLK_HZ/2-1 or p==CLK_HZ-1.
- The scan counter runs 0..SCAN_DIV-1 and wraps. scan_tick fires at SCAN_DIV-1 in every mode. The scan counter is not cleared by a reset press.
- Internal flag paused toggles on each pause press.
- Mode selection: mode = ADJ if the synced sw_adj is 1; otherwise PAUSE if paused; otherwise RUN.
- RUN: inc_sec = tick1.
- PAUSE: no increment strobes. The prescaler keeps running.
- ADJ: on each tick2, inc_sec pulses if sw_sel=1, otherwise inc_min pulses. No tick1 increments occur. Pause presses still toggle paused, so leaving ADJ returns to the mode paused selects.
- Reset press: cnt_clr=1 for one cycle, p cleared to 0, paused cleared. No inc_* strobe is issued in that cycle.
- Reset press and pause press in the same cycle: reset wins and paused ends at 0.
- Reset press during ADJ: the counter clears and mode stays ADJ.
- The outputs are registered; mode encoding never takes value 3.
- rst: every register cleared. Outputs after reset: inc_sec=0, inc_min=0, cnt_clr=0, blink=0, scan_tick=0, mode=RUN. Debounced levels = 0.

## Timing
- A raw button held high produces its press pulse at exactly DEB_CYCLES+3 rising edges after the first edge that samples it high.
- A raw switch change is visible on mode and in increment selection 3 edges after the edge that first samples it.
- Strobe latency: inc_*, cnt_clr and scan_tick are asserted the cycle after their enabling tick or press (registered outputs).
- A release shorter than DEB_CYCLES is ignored and no second press occurs. A held button gives exactly one pulse.
- A switch into ADJ mid-prescale does not restart p.

## Configuration
- STOPWATCH_BLINK_EN defined: in ADJ, blink toggles on every tick2, giving a 1 Hz blink of the selected field. Outside ADJ, blink is forced to 0 and the toggle register is cleared.
- STOPWATCH_BLINK_EN undefined: blink is tied to 0 and no blink register exists.

## Structure
- Package stopwatch_pkg: the mode encodings MODE_RUN/MODE_PAUSE/MODE_ADJ, the 2-bit mode typedef, and default CLK_HZ/DEB_CYCLES/SCAN_DIV constants.
- Sub-module btn_debounce (synchronizer + debounce counter + rise-edge pulse, parameter DEB_CYCLES), instantiated for btn_pse and btn_rst. The switches use the bare synchronizers in the top level.

## Test plan
Every scenario uses CLK_HZ=8, DEB_CYCLES=3, SCAN_DIV=4.
- Apply rst for 2 cycles, then idle 40 cycles → outputs at reset values, then mode=RUN, one inc_sec every 8 cycles, scan_tick every 4 cycles.
- Hold btn_pse for 10 cycles → a single pulse at edge 6, mode=PAUSE, inc_sec stops. A second press → mode=RUN and inc_sec resumes on the next tick1.
- A 2-cycle btn_pse glitch → no pulse, mode unchanged.
- sw_adj=1, sw_sel=0 for 16 cycles → inc_min every 4 cycles, no inc_sec. sw_sel=1 → inc_sec every 4 cycles. With STOPWATCH_BLINK_EN, blink toggles every 4 cycles.
- btn_rst and btn_pse raw-asserted on the same edge while PAUSE → cnt_clr pulses once, mode=RUN, the next inc_sec comes 8 cycles after the clear.
- btn_rst press while sw_adj=1 → cnt_clr pulse, mode stays ADJ, adjust strobes continue from p=0.
